// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and sequencing controller for the D/X/W integer pipeline.
//            Keeps shadow copies of the X- and W-stage destinations and uses
//            them to produce operand forwarding selects, load-use stalls,
//            memory-wait freezes and branch-redirect flushes.
// Ports    : clk, rst_n            - clock, async active-low reset
//            d_*                   - decode-stage instruction fields
//            x_redirect            - taken branch/jump resolved in X
//            mem_ready             - load data valid for the W-stage load
//            f_stall, d_stall      - hold F / D registers
//            x_bubble              - insert a bubble into X at the next edge
//            d_flush               - kill the instruction in D/F
//            fwd_op1_sel/op2_sel   - 0 = regfile, 1 = X result, 2 = W result
//            stall_cnt             - saturating count of stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NREG_BITS = 5,
    parameter int CNT_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 d_valid,
    input  logic [NREG_BITS-1:0] d_rs1,
    input  logic [NREG_BITS-1:0] d_rs2,
    input  logic                 d_rs1_used,
    input  logic                 d_rs2_used,
    input  logic [NREG_BITS-1:0] d_rd,
    input  logic                 d_rd_we,
    input  logic                 d_is_load,
    input  logic                 x_redirect,
    input  logic                 mem_ready,
    output logic                 f_stall,
    output logic                 d_stall,
    output logic                 x_bubble,
    output logic                 d_flush,
    output logic [1:0]           fwd_op1_sel,
    output logic [1:0]           fwd_op2_sel,
    output logic [CNT_BITS-1:0]  stall_cnt
);

    localparam logic [CNT_BITS-1:0] C_CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] C_CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // Shadow slots for the instructions currently in X and W.
    logic                 r_x_valid, r_x_we, r_x_is_load;
    logic [NREG_BITS-1:0] r_x_rd;
    logic                 r_w_valid, r_w_we, r_w_is_load;
    logic [NREG_BITS-1:0] r_w_rd;
    logic [CNT_BITS-1:0]  r_stall_cnt;

    logic w_wait, w_redir, w_lu_hit;
    logic w_x_hit1, w_x_hit2, w_w_hit1, w_w_hit2;
    logic w_stall;

    // A slot "hits" a source when it is a live writer of that register.
    // r0 is stored with we=0, so it can never hit.
    assign w_x_hit1 = d_rs1_used & r_x_valid & r_x_we & (d_rs1 == r_x_rd);
    assign w_x_hit2 = d_rs2_used & r_x_valid & r_x_we & (d_rs2 == r_x_rd);
    assign w_w_hit1 = d_rs1_used & r_w_valid & r_w_we & (d_rs1 == r_w_rd);
    assign w_w_hit2 = d_rs2_used & r_w_valid & r_w_we & (d_rs2 == r_w_rd);

    // Outstanding load in W without data freezes the whole pipe.
    assign w_wait   = r_w_valid & r_w_is_load & ~mem_ready;
    assign w_lu_hit = d_valid & r_x_is_load & (w_x_hit1 | w_x_hit2);
    assign w_redir  = x_redirect & r_x_valid & ~w_wait;

    // A redirect kills the consumer, so it overrides the load-use stall.
    assign w_stall  = w_wait | (w_lu_hit & ~w_redir);

    assign f_stall  = w_stall;
    assign d_stall  = w_stall;
    assign x_bubble = ~w_wait & (w_redir | w_lu_hit);
    assign d_flush  = w_redir;

    // A load in X has no result yet, so it cannot forward; fall through to W.
    // X is checked first because it is the youngest producer.
    assign fwd_op1_sel = (w_x_hit1 & ~r_x_is_load) ? 2'd1 :
                         w_w_hit1                  ? 2'd2 : 2'd0;
    assign fwd_op2_sel = (w_x_hit2 & ~r_x_is_load) ? 2'd1 :
                         w_w_hit2                  ? 2'd2 : 2'd0;

    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_valid   <= 1'b0;
            r_x_we      <= 1'b0;
            r_x_is_load <= 1'b0;
            r_x_rd      <= '0;
            r_w_valid   <= 1'b0;
            r_w_we      <= 1'b0;
            r_w_is_load <= 1'b0;
            r_w_rd      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (!w_wait) begin
                r_w_valid   <= r_x_valid;
                r_w_we      <= r_x_we;
                r_w_is_load <= r_x_is_load;
                r_w_rd      <= r_x_rd;
                if (x_bubble) begin
                    r_x_valid   <= 1'b0;
                    r_x_we      <= 1'b0;
                    r_x_is_load <= 1'b0;
                    r_x_rd      <= '0;
                end else begin
                    r_x_valid   <= d_valid;
                    r_x_we      <= d_valid & d_rd_we & (d_rd != '0);
                    r_x_is_load <= d_valid & d_is_load;
                    r_x_rd      <= d_valid ? d_rd : '0;
                end
            end
            if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Directed scenarios followed
//            by random stimulus, all compared against a queue-based model of
//            the instructions in flight.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int NREG_BITS = 5;
    localparam int CNT_BITS  = 4;
    localparam int CNT_MAX   = (1 << CNT_BITS) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 d_valid;
    logic [NREG_BITS-1:0] d_rs1, d_rs2, d_rd;
    logic                 d_rs1_used, d_rs2_used, d_rd_we, d_is_load;
    logic                 x_redirect, mem_ready;
    logic                 f_stall, d_stall, x_bubble, d_flush;
    logic [1:0]           fwd_op1_sel, fwd_op2_sel;
    logic [CNT_BITS-1:0]  stall_cnt;

    hazard_ctrl #(.NREG_BITS(NREG_BITS), .CNT_BITS(CNT_BITS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_valid     (d_valid),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .d_rs1_used  (d_rs1_used),
        .d_rs2_used  (d_rs2_used),
        .d_rd        (d_rd),
        .d_rd_we     (d_rd_we),
        .d_is_load   (d_is_load),
        .x_redirect  (x_redirect),
        .mem_ready   (mem_ready),
        .f_stall     (f_stall),
        .d_stall     (d_stall),
        .x_bubble    (x_bubble),
        .d_flush     (d_flush),
        .fwd_op1_sel (fwd_op1_sel),
        .fwd_op2_sel (fwd_op2_sel),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a two-entry queue of in-flight instructions,
    // index 0 is the younger one (in X), index 1 the older one (in W).
    // ------------------------------------------------------------------
    typedef struct packed {
        logic                 v;
        logic [NREG_BITS-1:0] rd;
        logic                 we;
        logic                 ld;
    } instr_t;

    instr_t pipe[$];
    int     m_cnt;
    logic   e_stall, e_bubble, e_flush;
    logic [1:0] e_f1, e_f2;

    function automatic void model_clear();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        m_cnt = 0;
    endfunction

    function automatic bit writes(instr_t s, logic [NREG_BITS-1:0] r);
        return s.v && s.we && (s.rd == r);
    endfunction

    // Youngest producer with a result available wins.
    function automatic logic [1:0] fwd_src(logic used, logic [NREG_BITS-1:0] r);
        if (!used) return 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (writes(pipe[i], r)) begin
                if (i == 0 && pipe[i].ld) continue;
                return (i == 0) ? 2'd1 : 2'd2;
            end
        end
        return 2'd0;
    endfunction

    function automatic bit freeze();
        return pipe[1].v && pipe[1].ld && !mem_ready;
    endfunction

    function automatic void model_eval();
        bit fz, kill, lu;
        fz   = freeze();
        lu   = d_valid && pipe[0].ld &&
               ((d_rs1_used && writes(pipe[0], d_rs1)) ||
                (d_rs2_used && writes(pipe[0], d_rs2)));
        kill = x_redirect && pipe[0].v && !fz;
        e_stall  = fz || (lu && !kill);
        e_bubble = !fz && (kill || lu);
        e_flush  = kill;
        e_f1 = fwd_src(d_rs1_used, d_rs1);
        e_f2 = fwd_src(d_rs2_used, d_rs2);
    endfunction

    function automatic void model_advance();
        instr_t n;
        if (!rst_n) begin
            model_clear();
            return;
        end
        model_eval();
        if (e_stall && m_cnt < CNT_MAX) m_cnt++;
        if (freeze()) return;
        n = '0;
        if (d_valid && !e_bubble) begin
            n.v  = 1'b1;
            n.rd = d_rd;
            n.we = d_rd_we && (d_rd != 0);
            n.ld = d_is_load;
        end
        void'(pipe.pop_back());
        pipe.push_front(n);
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers. Inputs change 1 time unit after the rising edge;
    // outputs are sampled on the falling edge.
    // ------------------------------------------------------------------
    task automatic set_d(input bit v, input int rs1, input bit u1, input int rs2,
                         input bit u2, input int rd, input bit we, input bit ld);
        d_valid    = v;
        d_rs1      = NREG_BITS'(rs1);
        d_rs1_used = u1;
        d_rs2      = NREG_BITS'(rs2);
        d_rs2_used = u2;
        d_rd       = NREG_BITS'(rd);
        d_rd_we    = we;
        d_is_load  = ld;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic sample();
        #4;
        model_eval();
        check("f_stall",     32'(f_stall),     32'(e_stall));
        check("d_stall",     32'(d_stall),     32'(e_stall));
        check("x_bubble",    32'(x_bubble),    32'(e_bubble));
        check("d_flush",     32'(d_flush),     32'(e_flush));
        check("fwd_op1_sel", 32'(fwd_op1_sel), 32'(e_f1));
        check("fwd_op2_sel", 32'(fwd_op2_sel), 32'(e_f2));
        check("stall_cnt",   32'(stall_cnt),   32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic cyc();
        sample();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        nop();
        x_redirect = 1'b0;
        mem_ready  = 1'b1;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        x_redirect = 1'b0;
        mem_ready  = 1'b1;
        nop();
        model_clear();
        @(posedge clk);
        #1;

        // Reset state: everything idle.
        sample();
        check("rst_d_stall",   32'(d_stall),     32'd0);
        check("rst_stall_cnt", 32'(stall_cnt),   32'd0);
        check("rst_fwd1",      32'(fwd_op1_sel), 32'd0);
        tick();
        rst_n = 1'b1;

        // Back-to-back ALU dependency forwards from X, one gap forwards from W.
        do_reset();
        set_d(1, 1, 1, 2, 1, 3, 1, 0); cyc();
        set_d(1, 3, 1, 3, 1, 4, 1, 0); sample();
        check("b2b_fwd1",  32'(fwd_op1_sel), 32'd1);
        check("b2b_fwd2",  32'(fwd_op2_sel), 32'd1);
        check("b2b_stall", 32'(d_stall),     32'd0);
        tick();
        set_d(1, 1, 1, 2, 1, 3, 1, 0); cyc();
        nop(); cyc();
        set_d(1, 3, 1, 3, 1, 4, 1, 0); sample();
        check("gap_fwd1", 32'(fwd_op1_sel), 32'd2);
        check("gap_fwd2", 32'(fwd_op2_sel), 32'd2);
        tick();

        // Load-use: one bubble, then forward from W.
        do_reset();
        set_d(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        set_d(1, 5, 1, 0, 0, 6, 1, 0); sample();
        check("lu_d_stall",  32'(d_stall),  32'd1);
        check("lu_f_stall",  32'(f_stall),  32'd1);
        check("lu_x_bubble", 32'(x_bubble), 32'd1);
        tick();
        sample();
        check("lu_fwd1",      32'(fwd_op1_sel), 32'd2);
        check("lu_release",   32'(d_stall),     32'd0);
        check("lu_stall_cnt", 32'(stall_cnt),   32'd1);
        tick();

        // Memory wait on a W-stage load for three cycles.
        do_reset();
        set_d(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        nop(); cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("mw_d_stall", 32'(d_stall), 32'd1);
            tick();
        end
        mem_ready = 1'b1;
        sample();
        check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw_release",   32'(d_stall),   32'd0);
        tick();

        // Redirect together with a load-use pair: flush wins, no stall.
        do_reset();
        set_d(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        set_d(1, 5, 1, 0, 0, 6, 1, 0);
        x_redirect = 1'b1;
        sample();
        check("rd_flush",  32'(d_flush),  32'd1);
        check("rd_bubble", 32'(x_bubble), 32'd1);
        check("rd_stall",  32'(d_stall),  32'd0);
        tick();
        x_redirect = 1'b0;

        // r0 is never tracked.
        do_reset();
        set_d(1, 1, 1, 2, 1, 0, 1, 0); cyc();
        set_d(1, 0, 1, 0, 1, 7, 1, 0); sample();
        check("r0_fwd1_x", 32'(fwd_op1_sel), 32'd0);
        check("r0_fwd2_x", 32'(fwd_op2_sel), 32'd0);
        tick();
        nop(); cyc();
        set_d(1, 0, 1, 0, 1, 7, 1, 0); sample();
        check("r0_fwd1_w", 32'(fwd_op1_sel), 32'd0);
        tick();

        // Counter saturation, then reset asserted in the middle of a stall.
        do_reset();
        set_d(1, 0, 0, 0, 0, 5, 1, 1); cyc();
        nop(); cyc();
        mem_ready = 1'b0;
        repeat (20) cyc();
        sample();
        check("sat_stall_cnt", 32'(stall_cnt), 32'(CNT_MAX));
        check("sat_d_stall",   32'(d_stall),   32'd1);
        rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_rst_d_stall",   32'(d_stall),   32'd0);
        check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b1;

        // Random traffic over a small register range to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            set_d($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0);
            x_redirect = $urandom_range(0, 6) == 0;
            mem_ready  = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_clear();
            end else begin
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
